state_cmd: RTL and testbench

// - Command-side driver for the CPU run-control FSM. It turns host commands into

---
 rtl/state_cmd.sv | 260 ++++++++++++++++++++++++++
 tb/tb_state_cmd.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/state_cmd.sv
// state_cmd
//   Command-side driver for the CPU run-control FSM. Turns host commands into
//   single-cycle run/cont/halt pulses, then watches the control state cs until
//   the requested transition is confirmed (done) or fails (err).
//
// Build option
//   STATE_CMD_STEP_EN : when defined, STEP (N-cycle single-step) is supported.
//                       When undefined, STEP is rejected in CHECK with err and
//                       step_n is ignored.
//
// Ports
//   clk        in   system clock, rising edge
//   reset      in   asynchronous, active-high reset
//   cmd_valid  in   host command valid
//   cmd_ready  out  command can be accepted (only in IDLE)
//   cmd[1:0]   in   00 START, 01 STOP, 10 RESUME, 11 STEP
//   step_n[7:0] in  STEP length in cycles, sampled on accept, 0 means 1
//   cs[2:0]    in   current state of the run-control FSM
//   run        out  one-cycle start pulse
//   cont       out  one-cycle continue pulse
//   halt       out  one-cycle halt pulse
//   busy       out  command FSM not in IDLE
//   done       out  one-cycle pulse, command confirmed
//   err        out  one-cycle pulse, command rejected / timed out / aborted
//
// State    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for a host command, cmd_ready high
// CHECK    | testing the precondition on cs for the latched command
// ISSUE    | control pulse is on the outputs this cycle
// WAIT_ACK | waiting for cs to reach the expected state
// STEPPING | counting cycles with cs == CS_RUN up to step_n
// WAIT_HALT| halt pulse issued, waiting for cs == CS_HALT
module state_cmd #(
  parameter int unsigned TIMEOUT = 16,
  parameter logic [2:0]  CS_IDLE = 3'd0,
  parameter logic [2:0]  CS_RUN  = 3'd1,
  parameter logic [2:0]  CS_HALT = 3'd2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd,
  input  logic [7:0] step_n,
  input  logic [2:0] cs,
  output logic       run,
  output logic       cont,
  output logic       halt,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int unsigned     TO_W    = $clog2(TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);
  localparam logic [TO_W-1:0] TO_MAX  = TO_W'(TIMEOUT);

  localparam logic [1:0] CMD_START  = 2'b00;
  localparam logic [1:0] CMD_STOP   = 2'b01;
  localparam logic [1:0] CMD_RESUME = 2'b10;
  localparam logic [1:0] CMD_STEP   = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_ISSUE, S_WAIT_ACK, S_STEPPING, S_WAIT_HALT
  } state_e;

  state_e          state_q, state_d;
  logic [1:0]      cmd_q, cmd_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d, to_cnt_inc;

  logic run_q, run_d, cont_q, cont_d, halt_q, halt_d;
  logic done_q, done_d, err_q, err_d;
  logic busy_q, busy_d, cmd_ready_q, cmd_ready_d;

  logic       pre_ok;
  logic [2:0] exp_cs;
  logic       ack_match, to_hit;

`ifdef STATE_CMD_STEP_EN
  logic [7:0] step_n_q, step_n_d;
  logic [7:0] step_cnt_q, step_cnt_d, step_cnt_inc;
  logic       step_hit, halt_match;

  // 9-bit compare so the +1 can never wrap into a false hit.
  assign step_hit     = ({1'b0, step_cnt_q} + 9'd1) == {1'b0, step_n_q};
  assign step_cnt_inc = (step_cnt_q == 8'hFF) ? step_cnt_q : step_cnt_q + 8'd1;
  assign halt_match   = (cs == CS_HALT);
`else
  logic unused_step_n;
  assign unused_step_n = ^step_n;
`endif

  always_comb begin
    pre_ok = 1'b0;
    case (cmd_q)
      CMD_START:  pre_ok = (cs == CS_IDLE);
      CMD_STOP:   pre_ok = (cs == CS_RUN);
      CMD_RESUME: pre_ok = (cs == CS_HALT);
`ifdef STATE_CMD_STEP_EN
      CMD_STEP:   pre_ok = (cs == CS_HALT);
`else
      CMD_STEP:   pre_ok = 1'b0;
`endif
      default:    pre_ok = 1'b0;
    endcase
  end

  assign exp_cs     = (cmd_q == CMD_STOP) ? CS_HALT : CS_RUN;
  assign ack_match  = (cs == exp_cs);
  // The counter is 0 in the pulse cycle, so hitting TIMEOUT-1 here puts the
  // err pulse exactly TIMEOUT cycles after the control pulse.
  assign to_hit     = (to_cnt_q == TO_LAST);
  assign to_cnt_inc = (to_cnt_q == TO_MAX) ? to_cnt_q : to_cnt_q + TO_W'(1);

  // State register (with datapath registers)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cmd_q      <= 2'b00;
      to_cnt_q   <= '0;
`ifdef STATE_CMD_STEP_EN
      step_n_q   <= 8'd0;
      step_cnt_q <= 8'd0;
`endif
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      to_cnt_q   <= to_cnt_d;
`ifdef STATE_CMD_STEP_EN
      step_n_q   <= step_n_d;
      step_cnt_q <= step_cnt_d;
`endif
    end
  end

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    to_cnt_d   = to_cnt_q;
`ifdef STATE_CMD_STEP_EN
    step_n_d   = step_n_q;
    step_cnt_d = step_cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          cmd_d   = cmd;
`ifdef STATE_CMD_STEP_EN
          step_n_d = (step_n == 8'd0) ? 8'd1 : step_n;
`endif
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        to_cnt_d = '0;
        state_d  = pre_ok ? S_ISSUE : S_IDLE;
      end
      S_ISSUE: begin
        to_cnt_d = to_cnt_inc;
        state_d  = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        to_cnt_d = to_cnt_inc;
        if (ack_match) begin
          state_d = S_IDLE;
`ifdef STATE_CMD_STEP_EN
          if (cmd_q == CMD_STEP) begin
            state_d    = S_STEPPING;
            step_cnt_d = 8'd0;
          end
`endif
        end else if (to_hit) begin
          state_d = S_IDLE;
        end
      end
`ifdef STATE_CMD_STEP_EN
      S_STEPPING: begin
        if (cs != CS_RUN) begin
          state_d = S_IDLE;
        end else begin
          step_cnt_d = step_cnt_inc;
          if (step_hit) begin
            state_d  = S_WAIT_HALT;
            to_cnt_d = '0;
          end
        end
      end
      S_WAIT_HALT: begin
        to_cnt_d = to_cnt_inc;
        if (halt_match || to_hit) state_d = S_IDLE;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic: computes the value every output takes after the next edge.
  always_comb begin
    run_d  = (state_q == S_CHECK) && pre_ok && (cmd_q == CMD_START);
    cont_d = (state_q == S_CHECK) && pre_ok &&
             ((cmd_q == CMD_RESUME) || (cmd_q == CMD_STEP));
    halt_d = (state_q == S_CHECK) && pre_ok && (cmd_q == CMD_STOP);
    done_d = 1'b0;
    err_d  = (state_q == S_CHECK) && !pre_ok;
    if (state_q == S_WAIT_ACK) begin
      if (ack_match) begin
`ifdef STATE_CMD_STEP_EN
        done_d = (cmd_q != CMD_STEP);
`else
        done_d = 1'b1;
`endif
      end else if (to_hit) begin
        err_d = 1'b1;
      end
    end
`ifdef STATE_CMD_STEP_EN
    if (state_q == S_STEPPING) begin
      if (cs != CS_RUN) err_d  = 1'b1;
      else if (step_hit) halt_d = 1'b1;
    end
    if (state_q == S_WAIT_HALT) begin
      if (halt_match)  done_d = 1'b1;
      else if (to_hit) err_d  = 1'b1;
    end
`endif
    busy_d      = (state_d != S_IDLE);
    cmd_ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      run_q       <= 1'b0;
      cont_q      <= 1'b0;
      halt_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      cmd_ready_q <= 1'b0;
    end else begin
      run_q       <= run_d;
      cont_q      <= cont_d;
      halt_q      <= halt_d;
      done_q      <= done_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
      cmd_ready_q <= cmd_ready_d;
    end
  end

  assign run       = run_q;
  assign cont      = cont_q;
  assign halt      = halt_q;
  assign done      = done_q;
  assign err       = err_q;
  assign busy      = busy_q;
  assign cmd_ready = cmd_ready_q;

endmodule

// File: tb/tb_state_cmd.sv
module tb_state_cmd;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd;
  logic [7:0] step_n;
  logic [2:0] cs;
  logic       run, cont, halt, busy, done, err;

  // Run-control FSM model: cs follows pulses one cycle later when enabled,
  // otherwise cs is forced by the test.
  logic       model_en = 1'b0;
  logic [2:0] cs_force = 3'd0;
  logic [2:0] cs_model;

  int n_tests = 0;
  int n_fail  = 0;

  int cyc = 0;
  int n_run = 0, n_cont = 0, n_halt = 0, n_done = 0, n_err = 0, n_excl = 0;
  int t_run = 0, t_cont = 0, t_halt = 0, t_done = 0, t_err = 0;
  int b_run, b_cont, b_halt, b_done, b_err;

  always #5 clk = ~clk;

  state_cmd dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd       (cmd),
    .step_n    (step_n),
    .cs        (cs),
    .run       (run),
    .cont      (cont),
    .halt      (halt),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always @(posedge clk) begin
    if (!model_en)  cs_model <= cs_force;
    else if (run)   cs_model <= 3'd1;
    else if (halt)  cs_model <= 3'd2;
    else if (cont)  cs_model <= 3'd1;
  end

  assign cs = model_en ? cs_model : cs_force;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (run)  begin n_run  <= n_run  + 1; t_run  <= cyc; end
    if (cont) begin n_cont <= n_cont + 1; t_cont <= cyc; end
    if (halt) begin n_halt <= n_halt + 1; t_halt <= cyc; end
    if (done) begin n_done <= n_done + 1; t_done <= cyc; end
    if (err)  begin n_err  <= n_err  + 1; t_err  <= cyc; end
    if ((int'(run) + int'(cont) + int'(halt)) > 1 || (done && err))
      n_excl <= n_excl + 1;
  end

  task automatic check_val(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic snap();
    b_run  = n_run;
    b_cont = n_cont;
    b_halt = n_halt;
    b_done = n_done;
    b_err  = n_err;
  endtask

  task automatic issue(input logic [1:0] c, input logic [7:0] sn);
    int i;
    snap();
    i = 0;
    while (!cmd_ready && i < 50) begin tick(); i++; end
    cmd_valid = 1'b1;
    cmd       = c;
    step_n    = sn;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_result();
    int i;
    i = 0;
    while (!(done || err) && i < 200) begin tick(); i++; end
    check_val("result_seen", int'(done || err), 1);
    tick();
  endtask

  task automatic run_cmd(input logic [1:0] c, input logic [7:0] sn);
    issue(c, sn);
    wait_result();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    int i;
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd       = 2'b00;
    step_n    = 8'd0;
    repeat (3) tick();
    check_val("rst_ready", int'(cmd_ready), 0);
    check_val("rst_busy",  int'(busy), 0);
    check_val("rst_outs",  int'({run, cont, halt, done, err}), 0);
    reset = 1'b0;
    tick();
    check_val("rel_ready", int'(cmd_ready), 1);
    check_val("rel_busy",  int'(busy), 0);
    model_en = 1'b1;

    // START from idle
    run_cmd(2'b00, 8'd0);
    check_val("start_run",  n_run - b_run, 1);
    check_val("start_oth",  (n_cont - b_cont) + (n_halt - b_halt), 0);
    check_val("start_done", n_done - b_done, 1);
    check_val("start_err",  n_err - b_err, 0);
    check_val("start_lat",  t_done - t_run, 2);
    check_val("start_rdy",  int'(cmd_ready), 1);
    check_val("start_cs",   int'(cs), 1);

    // STOP from running
    run_cmd(2'b01, 8'd0);
    check_val("stop_halt", n_halt - b_halt, 1);
    check_val("stop_done", n_done - b_done, 1);
    check_val("stop_lat",  t_done - t_halt, 2);
    check_val("stop_cs",   int'(cs), 2);

    // RESUME from halted
    run_cmd(2'b10, 8'd0);
    check_val("resume_cont", n_cont - b_cont, 1);
    check_val("resume_done", n_done - b_done, 1);
    check_val("resume_cs",   int'(cs), 1);

    // START while cs held at RUN: rejected
    cs_force = 3'd1;
    model_en = 1'b0;
    run_cmd(2'b00, 8'd0);
    check_val("badstart_err",   n_err - b_err, 1);
    check_val("badstart_done",  n_done - b_done, 0);
    check_val("badstart_pulse", (n_run - b_run) + (n_cont - b_cont) + (n_halt - b_halt), 0);

    // RESUME with no response: timeout
    cs_force = 3'd2;
    tick();
    run_cmd(2'b10, 8'd0);
    check_val("to_cont", n_cont - b_cont, 1);
    check_val("to_err",  n_err - b_err, 1);
    check_val("to_done", n_done - b_done, 0);
    check_val("to_lat",  t_err - t_cont, 16);

    tick();
    model_en = 1'b1;
    tick();
`ifdef STATE_CMD_STEP_EN
    run_cmd(2'b11, 8'd5);
    check_val("step5_cont", n_cont - b_cont, 1);
    check_val("step5_halt", n_halt - b_halt, 1);
    check_val("step5_span", t_halt - t_cont, 7);
    check_val("step5_done", n_done - b_done, 1);
    check_val("step5_err",  n_err - b_err, 0);
    check_val("step5_lat",  t_done - t_halt, 2);
    check_val("step5_cs",   int'(cs), 2);

    run_cmd(2'b11, 8'd0);
    check_val("step0_span", t_halt - t_cont, 3);
    check_val("step0_done", n_done - b_done, 1);

    // External halt while stepping
    issue(2'b11, 8'd20);
    i = 0;
    while (!cont && i < 20) begin tick(); i++; end
    check_val("exth_cont_seen", int'(cont), 1);
    repeat (4) tick();
    cs_force = 3'd2;
    model_en = 1'b0;
    wait_result();
    check_val("exth_err",  n_err - b_err, 1);
    check_val("exth_halt", n_halt - b_halt, 0);
    check_val("exth_done", n_done - b_done, 0);
    model_en = 1'b1;
    tick();

    // Reset in the middle of stepping
    issue(2'b11, 8'd50);
    i = 0;
    while (!cont && i < 20) begin tick(); i++; end
    repeat (5) tick();
    check_val("midrst_busy_pre", int'(busy), 1);
    reset = 1'b1;
    #1;
    check_val("midrst_outs",  int'({run, cont, halt, done, err}), 0);
    check_val("midrst_busy",  int'(busy), 0);
    check_val("midrst_ready", int'(cmd_ready), 0);
    tick();
    model_en = 1'b0;
    cs_force = 3'd2;
    reset    = 1'b0;
    snap();
    repeat (3) tick();
    check_val("postrst_ready", int'(cmd_ready), 1);
    check_val("postrst_busy",  int'(busy), 0);
    check_val("postrst_stray", (n_done - b_done) + (n_err - b_err), 0);
`else
    run_cmd(2'b11, 8'd5);
    check_val("stepdis_err",   n_err - b_err, 1);
    check_val("stepdis_done",  n_done - b_done, 0);
    check_val("stepdis_pulse", (n_run - b_run) + (n_cont - b_cont) + (n_halt - b_halt), 0);
`endif

    check_val("pulse_exclusive", n_excl, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
